otp_cipher_bank: RTL and testbench

OTP_CIPHER_BANK -- requirements
Module: otp_cipher_bank

---
 rtl/otp_pkg.sv | 20 ++
 rtl/otp_cipher_bank_if.sv | 28 ++
 rtl/otp_key_bank.sv | 57 +++++
 rtl/otp_cipher_bank.sv | 99 +++++++++
 tb/tb_otp_cipher_bank.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/otp_pkg.sv
// Shared FSM type, default constants and LFSR helper for the OTP cipher bank.
package otp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_WAIT_LOW = 2'd2
    } state_e;

    localparam int unsigned LFSR_MAX_W      = 64;
    localparam logic [15:0] OTP_DEFAULT_KEY = 16'h3327;
    localparam logic [15:0] OTP_LFSR_TAPS   = 16'hB400;

    // One Galois step, right-shifting; callers zero-extend to LFSR_MAX_W and truncate back.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(input logic [LFSR_MAX_W-1:0] value,
                                                        input logic [LFSR_MAX_W-1:0] taps);
        lfsr_step = (value >> 1) ^ (value[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/otp_cipher_bank_if.sv
// Transaction and key-write bus of the OTP cipher bank.
interface otp_cipher_bank_if #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned KEY_SLOTS = 4
);
    localparam int unsigned SEL_W = $clog2(KEY_SLOTS);

    logic [DATA_W-1:0] input_data;
    logic              start;
    logic              passthrough;
    logic [SEL_W-1:0]  key_sel;
    logic              key_wr;
    logic [SEL_W-1:0]  key_wr_sel;
    logic [DATA_W-1:0] key_data;
    logic [DATA_W-1:0] output_data;
    logic              done;
    logic              busy;

    modport master (
        output input_data, start, passthrough, key_sel, key_wr, key_wr_sel, key_data,
        input  output_data, done, busy
    );

    modport slave (
        input  input_data, start, passthrough, key_sel, key_wr, key_wr_sel, key_data,
        output output_data, done, busy
    );
endinterface

// File: rtl/otp_key_bank.sv
// Key slot registers with write port and read mux; optional per-use LFSR rotation
// under OTP_KEY_ROTATE_EN.
module otp_key_bank
    import otp_pkg::*;
#(
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       KEY_SLOTS   = 4,
    parameter logic [DATA_W-1:0] DEFAULT_KEY = DATA_W'(OTP_DEFAULT_KEY),
    parameter logic [DATA_W-1:0] LFSR_TAPS   = DATA_W'(OTP_LFSR_TAPS)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wr,
    input  logic [$clog2(KEY_SLOTS)-1:0] wr_sel,
    input  logic [DATA_W-1:0]            wr_data,
`ifdef OTP_KEY_ROTATE_EN
    input  logic                         rotate,
`endif
    input  logic [$clog2(KEY_SLOTS)-1:0] rd_sel,
    output logic [DATA_W-1:0]            rd_data_c
);

    logic [DATA_W-1:0] keys [KEY_SLOTS];

    // Configuration sanity; a clear taps MSB would leave the top key bit stuck at zero.
    if (DATA_W < 8 || DATA_W > LFSR_MAX_W) begin : g_bad_width
        $error("otp_key_bank: DATA_W out of range");
    end
    if (KEY_SLOTS < 2 || (KEY_SLOTS & (KEY_SLOTS - 1)) != 0) begin : g_bad_slots
        $error("otp_key_bank: KEY_SLOTS must be a power of two >= 2");
    end
    if (LFSR_TAPS[DATA_W-1] == 1'b0) begin : g_bad_taps
        $error("otp_key_bank: LFSR_TAPS must include the MSB");
    end

    // Write is issued after rotation so a same-slot write overrides the rotated value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < KEY_SLOTS; i++) begin
                keys[i] <= DEFAULT_KEY;
            end
        end else begin
`ifdef OTP_KEY_ROTATE_EN
            if (rotate) begin
                keys[rd_sel] <= DATA_W'(lfsr_step(LFSR_MAX_W'(keys[rd_sel]),
                                                  LFSR_MAX_W'(LFSR_TAPS)));
            end
`endif
            if (wr) begin
                keys[wr_sel] <= wr_data;
            end
        end
    end

    assign rd_data_c = keys[rd_sel];

endmodule

// File: rtl/otp_cipher_bank.sv
// One-time-pad XOR cipher with a bank of key slots and a start/done handshake.
// Optional key rotation per use: define OTP_KEY_ROTATE_EN.
module otp_cipher_bank
    import otp_pkg::*;
#(
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       KEY_SLOTS   = 4,
    parameter logic [DATA_W-1:0] DEFAULT_KEY = DATA_W'(OTP_DEFAULT_KEY),
    parameter logic [DATA_W-1:0] LFSR_TAPS   = DATA_W'(OTP_LFSR_TAPS)
) (
    input  logic             clk,
    input  logic             reset_n,
    otp_cipher_bank_if.slave bus
);

    localparam int unsigned SEL_W = $clog2(KEY_SLOTS);

    state_e            state, state_nxt;
    logic [DATA_W-1:0] cap_data, cap_data_nxt;
    logic [SEL_W-1:0]  cap_sel, cap_sel_nxt;
    logic [DATA_W-1:0] out_q, out_nxt;
    logic              done_q, done_nxt;
    logic              busy_q, busy_nxt;
    logic [DATA_W-1:0] key_c;

    otp_key_bank #(
        .DATA_W      (DATA_W),
        .KEY_SLOTS   (KEY_SLOTS),
        .DEFAULT_KEY (DEFAULT_KEY),
        .LFSR_TAPS   (LFSR_TAPS)
    ) u_key_bank (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr        (bus.key_wr),
        .wr_sel    (bus.key_wr_sel),
        .wr_data   (bus.key_data),
`ifdef OTP_KEY_ROTATE_EN
        .rotate    (state == ST_EXEC),
`endif
        .rd_sel    (cap_sel),
        .rd_data_c (key_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cap_data <= '0;
            cap_sel  <= '0;
            out_q    <= '0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cap_data <= cap_data_nxt;
            cap_sel  <= cap_sel_nxt;
            out_q    <= out_nxt;
            done_q   <= done_nxt;
            busy_q   <= busy_nxt;
        end
    end

    // Next state and next registered outputs; passthrough only acts from IDLE.
    always_comb begin
        state_nxt    = state;
        cap_data_nxt = cap_data;
        cap_sel_nxt  = cap_sel;
        out_nxt      = out_q;
        done_nxt     = 1'b1;
        busy_nxt     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.passthrough) begin
                    out_nxt = bus.input_data;
                end else if (bus.start) begin
                    cap_data_nxt = bus.input_data;
                    cap_sel_nxt  = bus.key_sel;
                    done_nxt     = 1'b0;
                    busy_nxt     = 1'b1;
                    state_nxt    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                out_nxt   = cap_data ^ key_c;
                state_nxt = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!bus.start) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.output_data = out_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_otp_cipher_bank.sv
// Scoreboard bench for otp_cipher_bank: stimulus pushes expected results, a monitor pops them on done.
module tb_otp_cipher_bank;

    localparam int unsigned DW = 16;
    localparam int unsigned NS = 4;

    logic clk = 1'b0;
    logic reset_n;

    otp_cipher_bank_if #(.DATA_W(DW), .KEY_SLOTS(NS)) bus ();

    otp_cipher_bank #(
        .DATA_W      (DW),
        .KEY_SLOTS   (NS),
        .DEFAULT_KEY (16'h3327),
        .LFSR_TAPS   (16'hB400)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          checks    = 0;
    int          passes    = 0;
    int          pulses    = 0;
    int          low_len   = 0;
    bit          prev_done = 1'b1;
    logic [15:0] exp_q[$];
    logic [15:0] mkey [NS];
    logic [15:0] mon_exp;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic m_reset();
        for (int i = 0; i < NS; i++) mkey[i] = 16'h3327;
    endtask

`ifdef OTP_KEY_ROTATE_EN
    function automatic logic [15:0] m_lfsr(input logic [15:0] k);
        return k[0] ? ((k >> 1) ^ 16'hB400) : (k >> 1);
    endfunction
`endif

    // Expected ciphertext from the slot's current model value; used slot then rotates.
    task automatic push_txn(input logic [15:0] d, input logic [1:0] s);
        exp_q.push_back(d ^ mkey[s]);
`ifdef OTP_KEY_ROTATE_EN
        mkey[s] = m_lfsr(mkey[s]);
`endif
    endtask

    // Monitor: every done rising edge must deliver the oldest expected result.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_done = 1'b1;
            low_len   = 0;
        end else begin
            if (!bus.done) begin
                low_len++;
                check_eq("busy_in_exec", 32'(bus.busy), 32'd1);
            end else if (!prev_done) begin
                pulses++;
                check_eq("done_low_cycles", 32'(low_len), 32'd1);
                check_eq("busy_after_done", 32'(bus.busy), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL sb_unexpected: got 0x%0h, required no result", bus.output_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check_eq("result", 32'(bus.output_data), 32'(mon_exp));
                end
                low_len = 0;
            end
            prev_done = bus.done;
        end
    end

    task automatic write_key(input logic [1:0] s, input logic [15:0] v);
        bus.key_wr = 1'b1; bus.key_wr_sel = s; bus.key_data = v;
        @(posedge clk); #1;
        bus.key_wr = 1'b0;
        mkey[s] = v;
    endtask

    // Transaction from IDLE; optional key write and passthrough raised during EXEC.
    task automatic do_txn(input logic [15:0] d, input logic [1:0] s, input bit cw,
                          input logic [1:0] cws, input logic [15:0] cwv, input bit ptm);
        bus.passthrough = 1'b0; bus.start = 1'b1; bus.input_data = d; bus.key_sel = s;
        push_txn(d, s);
        @(posedge clk); #1;
        bus.input_data = 16'($urandom);
        bus.key_sel    = 2'($urandom);
        if (ptm) bus.passthrough = 1'b1;
        if (cw) begin
            bus.key_wr = 1'b1; bus.key_wr_sel = cws; bus.key_data = cwv;
            mkey[cws] = cwv;
        end
        @(posedge clk); #1;
        bus.key_wr = 1'b0; bus.passthrough = 1'b0; bus.start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic hold_txn(input logic [15:0] d, input logic [1:0] s);
        int p0;
        p0 = pulses;
        bus.start = 1'b1; bus.input_data = d; bus.key_sel = s;
        push_txn(d, s);
        repeat (10) begin
            @(posedge clk); #1;
            bus.input_data = 16'($urandom);
            bus.key_sel    = 2'($urandom);
        end
        check_eq("held_start_pulses", 32'(pulses - p0), 32'd1);
        bus.start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int          p0;
        logic [15:0] v;
        reset_n = 1'b0;
        bus.start = 1'b0; bus.passthrough = 1'b0; bus.input_data = '0; bus.key_sel = '0;
        bus.key_wr = 1'b0; bus.key_wr_sel = '0; bus.key_data = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_output", 32'(bus.output_data), 32'h0);
        check_eq("rst_done", 32'(bus.done), 32'd1);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_output", 32'(bus.output_data), 32'h0);
        check_eq("post_rst_done", 32'(bus.done), 32'd1);
        check_eq("post_rst_busy", 32'(bus.busy), 32'd0);

        do_txn(16'h0000, 2'd0, 1'b0, 2'd0, 16'h0, 1'b0);
        do_txn(16'h0000, 2'd0, 1'b0, 2'd0, 16'h0, 1'b0);
        for (int s = 1; s < NS; s++) do_txn(16'h0000, 2'(s), 1'b0, 2'd0, 16'h0, 1'b0);
        do_txn(16'h1234, 2'd0, 1'b0, 2'd0, 16'h0, 1'b0);

        hold_txn(16'h1234, 2'd1);
        do_txn(16'h1234, 2'd1, 1'b0, 2'd0, 16'h0, 1'b0);

        write_key(2'd2, 16'hFFFF);
        do_txn(16'h00FF, 2'd2, 1'b0, 2'd0, 16'h0, 1'b0);
        do_txn(16'h00FF, 2'd0, 1'b0, 2'd0, 16'h0, 1'b0);

        // Same-edge write to the slot in use, with passthrough raised mid-transaction.
        do_txn(16'h0F0F, 2'd1, 1'b1, 2'd1, 16'h5A5A, 1'b1);
        do_txn(16'h0000, 2'd1, 1'b0, 2'd0, 16'h0, 1'b0);

        p0 = pulses;
        bus.passthrough = 1'b1;
        for (int i = 0; i < 6; i++) begin
            v = (i == 0) ? 16'hABCD : 16'($urandom);
            bus.input_data = v;
            bus.start      = 1'($urandom);
            @(posedge clk); #1;
            check_eq("pass_output", 32'(bus.output_data), 32'(v));
            check_eq("pass_done", 32'(bus.done), 32'd1);
        end
        bus.passthrough = 1'b0; bus.start = 1'b0;
        @(posedge clk); #1;
        check_eq("pass_no_pulse", 32'(pulses - p0), 32'd0);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) write_key(2'($urandom), 16'($urandom));
            do_txn(16'($urandom), 2'($urandom), 1'($urandom_range(0, 3) == 0),
                   2'($urandom), 16'($urandom), 1'($urandom));
        end

        // Reset in the middle of EXEC, then release with start already high.
        bus.start = 1'b1; bus.input_data = 16'h5555; bus.key_sel = 2'd0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check_eq("midexec_rst_output", 32'(bus.output_data), 32'h0);
        check_eq("midexec_rst_done", 32'(bus.done), 32'd1);
        check_eq("midexec_rst_busy", 32'(bus.busy), 32'd0);
        m_reset();
        bus.input_data = 16'h0000;
        push_txn(16'h0000, 2'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_eq("start_at_release_busy", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        do_txn(16'h0000, 2'd2, 1'b0, 2'd0, 16'h0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
